// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single-ported memory between an instruction-fetch port and a
// data load/store port. One access is in flight at a time; each access holds
// the memory for LATENCY cycles. When both ports want the memory in the same
// idle cycle, the port that was not granted most recently wins.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous reset, active low
//   if_req     : fetch request, held until if_done
//   if_addr    : fetch address
//   if_rdata   : fetched word, registered, held until the next fetch completes
//   if_done    : one-cycle fetch completion pulse
//   d_req      : load/store request, held until d_done
//   d_we       : 1 = store, 0 = load
//   d_addr     : load/store address
//   d_wdata    : store data
//   d_rdata    : load result, registered, held until the next load completes
//   d_done     : one-cycle load/store completion pulse
//   mem_en     : memory access active
//   mem_we     : memory write strobe (final access cycle of a store only)
//   mem_addr   : memory address (latched at grant)
//   mem_wdata  : memory write data (latched at grant)
//   mem_rdata  : memory read data, valid in the final access cycle
//   stall      : pipeline hold, high while any request is still outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_arbiter: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
    localparam logic       GRANT_IF = 1'b0;
    localparam logic       GRANT_D  = 1'b1;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic                r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;
    logic                r_if_done;
    logic                r_d_done;

    logic                w_if_elig;
    logic                w_d_elig;
    logic                w_grant_if;
    logic                w_grant_d;
    logic                w_final;
    logic                w_mem_en;
    logic                w_mem_we;

    // A port whose done pulse is showing this cycle has just been served and
    // must not be re-granted on its still-high request.
    assign w_if_elig = if_req & ~r_if_done;
    assign w_d_elig  = d_req  & ~r_d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_final      = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Under contention IF wins only if D was the last port served.
                if (w_if_elig && (!w_d_elig || r_last_grant == GRANT_D)) begin
                    w_grant_if   = 1'b1;
                    w_next_state = S_BUSY_IF;
                end else if (w_d_elig) begin
                    w_grant_d    = 1'b1;
                    w_next_state = S_BUSY_D;
                end
            end
            S_BUSY_IF: begin
                w_mem_en = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_final      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY_D: begin
                w_mem_en = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_final      = 1'b1;
                    w_mem_we     = r_we;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= 4'd0;
            r_last_grant <= GRANT_D;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= 32'd0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            if (w_grant_if) begin
                r_addr       <= if_addr;
                r_we         <= 1'b0;
                r_cnt        <= LAT_M1;
                r_last_grant <= GRANT_IF;
            end else if (w_grant_d) begin
                r_addr       <= d_addr;
                r_we         <= d_we;
                r_wdata      <= d_wdata;
                r_cnt        <= LAT_M1;
                r_last_grant <= GRANT_D;
            end else if (w_mem_en) begin
                if (w_final) begin
                    if (r_state == S_BUSY_IF) begin
                        r_if_rdata <= mem_rdata;
                        r_if_done  <= 1'b1;
                    end else begin
                        // Stores leave the previous load result in place.
                        if (!r_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_done <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_done   = r_if_done;
    assign d_done    = r_d_done;
    assign stall     = (if_req & ~r_if_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by two independent randomized port drivers.
// Each issued transaction pushes its expected outcome onto a per-port queue;
// a monitor on the falling edge plays the memory device and, whenever a done
// pulse appears, pops and compares read data, access length, address and
// write behaviour.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [31:0]   if_rdata;
    logic          if_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [31:0]   d_rdata;
    logic          d_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          stall;

    mem_arbiter #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q_if[$];
    exp_t        q_d[$];
    logic [31:0] ref_mem[128];
    logic [31:0] ref_d_rdata;
    logic [31:0] pmem[128];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h01010101) ^ 32'hC0DE0000;
    endfunction

    function automatic logic [31:0] rand_addr(bit region);
        logic [31:0] r;
        r = $urandom;
        return {r[31:9], region, r[7:2], 2'b00};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Waits for the port's done pulse; optionally drops the request once the
    // port's own access is visible on the memory bus.
    task automatic wait_done(input bit port, input logic [31:0] a, input bit drop,
                             output int n, output int dc);
        bit dropped;
        bit seen;
        dropped = 1'b0;
        seen    = 1'b0;
        n       = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (port ? d_done : if_done) begin
                seen = 1'b1;
                break;
            end
            if (drop && !dropped && mem_en && mem_addr == a) begin
                @(posedge clk);
                #1;
                if (port) d_req = 1'b0;
                else      if_req = 1'b0;
                dropped = 1'b1;
            end else begin
                @(posedge clk);
            end
            n++;
        end
        dc = cyc;
        chk(port ? "d_done_seen" : "if_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic if_txn(input logic [31:0] a, input bit drop, input bit keep,
                          output int n, output int dc);
        exp_t e;
        e.addr  = a;
        e.we    = 1'b0;
        e.wdata = 32'd0;
        e.rdata = ref_mem[a[8:2]];
        q_if.push_back(e);
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = a;
        wait_done(1'b0, a, drop, n, dc);
        if (!keep) begin
            @(posedge clk);
            #1;
            if_req = 1'b0;
        end
    endtask

    task automatic d_txn(input logic [31:0] a, input bit we, input logic [31:0] wd,
                         input bit drop, input bit keep, output int n, output int dc);
        exp_t e;
        e.addr  = a;
        e.we    = we;
        e.wdata = wd;
        if (we) begin
            ref_mem[a[8:2]] = wd;
            e.rdata = ref_d_rdata;
        end else begin
            e.rdata = ref_mem[a[8:2]];
            ref_d_rdata = e.rdata;
        end
        q_d.push_back(e);
        @(posedge clk);
        #1;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        wait_done(1'b1, a, drop, n, dc);
        if (!keep) begin
            @(posedge clk);
            #1;
            d_req = 1'b0;
        end
    endtask

    // Monitor and memory device
    initial begin
        int          en_cnt;
        int          we_cnt;
        logic [31:0] first_addr;
        logic [31:0] we_data;
        bit          addr_bad;
        exp_t        e;
        en_cnt = 0;
        we_cnt = 0;
        first_addr = '0;
        we_data = '0;
        addr_bad = 1'b0;
        for (int i = 0; i < 128; i++) pmem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_cnt = 0;
                we_cnt = 0;
                addr_bad = 1'b0;
                continue;
            end
            chk("stall", 32'(stall), 32'((if_req & ~if_done) | (d_req & ~d_done)));
            chk("we_without_en", 32'(mem_we & ~mem_en), 32'd0);
            if (mem_en) begin
                if (en_cnt == 0) first_addr = mem_addr;
                else if (mem_addr != first_addr) addr_bad = 1'b1;
                en_cnt++;
                if (mem_we) begin
                    we_cnt++;
                    we_data = mem_wdata;
                    pmem[mem_addr[8:2]] = mem_wdata;
                end
            end
            mem_rdata = mem_en ? pmem[mem_addr[8:2]] : (32'hBAD00000 | 32'(cyc));
            chk("both_done", 32'(if_done & d_done), 32'd0);
            if (if_done) begin
                if (q_if.size() == 0) begin
                    chk("if_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q_if.pop_front();
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("if_access_cycles", 32'(en_cnt), 32'(LAT));
                    chk("if_addr", first_addr, e.addr);
                    chk("if_addr_stable", 32'(addr_bad), 32'd0);
                    chk("if_we_cycles", 32'(we_cnt), 32'd0);
                end
                en_cnt = 0;
                we_cnt = 0;
                addr_bad = 1'b0;
            end
            if (d_done) begin
                if (q_d.size() == 0) begin
                    chk("d_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q_d.pop_front();
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_access_cycles", 32'(en_cnt), 32'(LAT));
                    chk("d_addr", first_addr, e.addr);
                    chk("d_addr_stable", 32'(addr_bad), 32'd0);
                    chk("d_we_cycles", 32'(we_cnt), 32'(e.we));
                    if (e.we) chk("d_wdata", we_data, e.wdata);
                end
                en_cnt = 0;
                we_cnt = 0;
                addr_bad = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2, dc1, dc2, n, dc;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        ref_d_rdata = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First contention after reset goes to IF, D follows LAT+1 cycles later
        fork
            begin if_txn(32'h00000020, 1'b0, 1'b0, n1, dc1); end
            begin d_txn(32'h00000120, 1'b0, 32'd0, 1'b0, 1'b0, n2, dc2); end
        join
        chk("rr1_if_latency", 32'(n1), 32'(LAT + 1));
        chk("rr1_d_after_if", 32'(dc2 - dc1), 32'(LAT + 1));

        // IF served alone, so the next contention must go to D
        if_txn(32'h00000030, 1'b0, 1'b0, n, dc);
        fork
            begin if_txn(32'h00000034, 1'b0, 1'b0, n1, dc1); end
            begin d_txn(32'h00000134, 1'b0, 32'd0, 1'b0, 1'b0, n2, dc2); end
        join
        chk("rr2_d_latency", 32'(n2), 32'(LAT + 1));
        chk("rr2_if_after_d", 32'(dc1 - dc2), 32'(LAT + 1));

        // Uncontended fetch
        if_txn(32'h00000010, 1'b0, 1'b0, n, dc);
        chk("fetch_latency", 32'(n), 32'(LAT + 1));
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

        // Store
        d_txn(32'h00000040, 1'b1, 32'h12345678, 1'b0, 1'b0, n, dc);
        chk("store_latency", 32'(n), 32'(LAT + 1));
        chk("store_keeps_d_rdata", d_rdata, ref_d_rdata);

        // Request dropped after the access started
        d_txn(32'h000001A0, 1'b0, 32'd0, 1'b1, 1'b0, n, dc);
        chk("drop_latency", 32'(n), 32'(LAT + 1));
        repeat (4) begin
            @(negedge clk);
            chk("drop_idle_mem_en", 32'(mem_en), 32'd0);
            chk("drop_no_second_done", 32'(d_done), 32'd0);
        end

        // Reset in the middle of a store
        @(posedge clk);
        #1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h00000180;
        d_wdata = 32'hA5A55A5A;
        @(posedge clk);
        #3;
        chk("abort_busy_before_reset", 32'(mem_en), 32'd1);
        rst = 1'b0;
        #1;
        ref_d_rdata = 32'd0;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_d_done", 32'(d_done), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_d_rdata", d_rdata, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_we", 32'(mem_we), 32'd0);
            chk("abort_no_done", 32'(d_done), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        begin
            exp_t e;
            e.addr  = 32'h00000180;
            e.we    = 1'b1;
            e.wdata = 32'hA5A55A5A;
            e.rdata = ref_d_rdata;
            ref_mem[e.addr[8:2]] = e.wdata;
            q_d.push_back(e);
        end
        wait_done(1'b1, 32'h00000180, 1'b0, n, dc);
        chk("regrant_latency", 32'(n), 32'(LAT + 1));
        @(posedge clk);
        #1;
        d_req = 1'b0;
        d_txn(32'h00000180, 1'b0, 32'd0, 1'b0, 1'b0, n, dc);
        chk("load_after_regrant", d_rdata, 32'hA5A55A5A);

        // Randomized traffic on both ports
        fork
            begin : drv_if
                int gap, rn, rdc;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 3);
                    if_txn(rand_addr(1'b0), ($urandom_range(0, 4) == 0),
                           (gap == 0 && i != 39), rn, rdc);
                    if (gap > 1) repeat (gap - 1) @(posedge clk);
                end
            end
            begin : drv_d
                int gap, rn, rdc;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 3);
                    d_txn(rand_addr(1'b1), 1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 4) == 0), (gap == 0 && i != 39), rn, rdc);
                    if (gap > 1) repeat (gap - 1) @(posedge clk);
                end
            end
        join

        repeat (10) @(negedge clk);
        chk("if_queue_empty", 32'(q_if.size()), 32'd0);
        chk("d_queue_empty", 32'(q_d.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
